// File: rtl/riscv_pkg.sv
// riscv_pkg: constants and encodings shared by the multi-cycle RISC-V datapath.
//   XLEN                 datapath width (PC, immediates, adders)
//   INSTR_BYTES          size of one instruction in bytes (sequential PC step)
//   RESET_VECTOR_DEFAULT PC value loaded while reset is asserted
//   cu_state_e           control-unit state encoding (init..wb)
//   alu_sel_e            add/sub selector used by the surrounding control
//   is_misaligned()      true when a byte address is not 4-byte aligned
package riscv_pkg;

  localparam int unsigned XLEN        = 64;
  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] RESET_VECTOR_DEFAULT = '0;

  typedef enum logic [2:0] {
    CU_INIT   = 3'd0,
    CU_FETCH  = 3'd1,
    CU_DECODE = 3'd2,
    CU_EX     = 3'd3,
    CU_WB     = 3'd4
  } cu_state_e;

  typedef enum logic [1:0] {
    SEL_NAO     = 2'd0,
    SEL_SOMA    = 2'd1,
    SEL_SUBTRAI = 2'd2
  } alu_sel_e;

  function automatic logic is_misaligned(input logic [1:0] addr_lsbs);
    return addr_lsbs != 2'b00;
  endfunction

endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if: bundle between the control unit / datapath (master) and the
// program-counter block (slave).
//   atualiza_pc  master->slave  PC update enable (one cycle per instruction)
//   soma_imm     master->slave  next-PC select: 1 = PC+imm, 0 = PC+INSTR_BYTES
//   imm          master->slave  sign-extended byte offset
//   dout         slave->master  current PC
//   next_pc      slave->master  combinational next PC
//   pc_plus4     slave->master  combinational PC+INSTR_BYTES (link address)
//   misaligned   slave->master  next_pc not 4-byte aligned (informational)
interface pc_unit_if #(
  parameter int unsigned XLEN = riscv_pkg::XLEN
);

  logic            atualiza_pc;
  logic            soma_imm;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] dout;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] pc_plus4;
  logic            misaligned;

  modport master (
    output atualiza_pc,
    output soma_imm,
    output imm,
    input  dout,
    input  next_pc,
    input  pc_plus4,
    input  misaligned
  );

  modport slave (
    input  atualiza_pc,
    input  soma_imm,
    input  imm,
    output dout,
    output next_pc,
    output pc_plus4,
    output misaligned
  );

endinterface

// File: rtl/pc_adder.sv
// pc_adder: purely combinational next-PC ALU.
//   pc          current PC
//   imm         sign-extended byte offset (two's complement)
//   soma_imm    1 = pc+imm, 0 = pc+INSTR_BYTES
//   next_pc     selected next address (modulo 2^XLEN, wrap is silent)
//   pc_plus4    pc+INSTR_BYTES regardless of soma_imm
//   misaligned  next_pc[1:0] != 0
module pc_adder #(
  parameter int unsigned XLEN        = riscv_pkg::XLEN,
  parameter int unsigned INSTR_BYTES = riscv_pkg::INSTR_BYTES
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic            soma_imm,
  output logic [XLEN-1:0] next_pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            misaligned
);

  import riscv_pkg::*;

  localparam logic [XLEN-1:0] STEP = XLEN'(INSTR_BYTES);

  logic [XLEN-1:0] sum_seq;
  logic [XLEN-1:0] sum_rel;

  // Both sums are computed separately so an undriven imm cannot leak into
  // next_pc while the sequential path is selected.
  always_comb begin
    sum_seq    = pc + STEP;
    sum_rel    = pc + imm;
    next_pc    = soma_imm ? sum_rel : sum_seq;
    pc_plus4   = sum_seq;
    misaligned = is_misaligned(next_pc[1:0]);
  end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: program-counter register plus its dedicated next-PC adder.
//   clk    system clock, rising edge
//   reset  asynchronous, active-low; forces dout to RESET_VECTOR
//   bus    pc_unit_if.slave: atualiza_pc/soma_imm/imm in,
//          dout/next_pc/pc_plus4/misaligned out
module pc_unit #(
  parameter int unsigned     XLEN         = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = riscv_pkg::RESET_VECTOR_DEFAULT,
  parameter int unsigned     INSTR_BYTES  = riscv_pkg::INSTR_BYTES
) (
  input  logic     clk,
  input  logic     reset,
  pc_unit_if.slave bus
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] pc_plus4;
  logic            misaligned;

  pc_adder #(
    .XLEN        (XLEN),
    .INSTR_BYTES (INSTR_BYTES)
  ) u_adder (
    .pc         (pc_q),
    .imm        (bus.imm),
    .soma_imm   (bus.soma_imm),
    .next_pc    (next_pc),
    .pc_plus4   (pc_plus4),
    .misaligned (misaligned)
  );

  // A misaligned next_pc is still loaded; trapping is the control unit's job.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_VECTOR;
    end else if (bus.atualiza_pc) begin
      pc_q <= next_pc;
    end
  end

  assign bus.dout       = pc_q;
  assign bus.next_pc    = next_pc;
  assign bus.pc_plus4   = pc_plus4;
  assign bus.misaligned = misaligned;

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

  localparam logic [63:0] RV = 64'h0;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  pc_unit_if #(.XLEN(64)) bus ();

  pc_unit #(
    .XLEN         (64),
    .RESET_VECTOR (RV),
    .INSTR_BYTES  (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the architectural PC as a plain variable.
  logic [63:0] m_pc = RV;

  always @(posedge clk or negedge reset) begin
    if (!reset) m_pc <= RV;
    else if (bus.atualiza_pc) m_pc <= bus.soma_imm ? m_pc + bus.imm : m_pc + 64'd4;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [63:0] e_next;
    e_next = bus.soma_imm ? m_pc + bus.imm : m_pc + 64'd4;
    chk("cyc_dout", bus.dout, m_pc);
    chk("cyc_pc_plus4", bus.pc_plus4, m_pc + 64'd4);
    if (bus.soma_imm || !$isunknown(bus.imm) || 1'b1) begin
      chk("cyc_next_pc", bus.next_pc, e_next);
      chk("cyc_misaligned", {63'd0, bus.misaligned}, {63'd0, (e_next[1:0] != 2'b00)});
    end
    if (!bus.soma_imm) chk("cyc_next_known", {63'd0, $isunknown(bus.next_pc)}, 64'd0);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    @(posedge clk);
    #1 bus.atualiza_pc = 1'b1;
    @(posedge clk);
    #1 bus.atualiza_pc = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    reset           = 1'b0;
    bus.atualiza_pc = 1'b0;
    bus.soma_imm    = 1'b0;
    bus.imm         = '0;
    tick(2);
    chk("rst_dout", bus.dout, 64'h0);
    chk("rst_next_pc", bus.next_pc, 64'h4);
    chk("rst_pc_plus4", bus.pc_plus4, 64'h4);
    chk("rst_misaligned", {63'd0, bus.misaligned}, 64'd0);

    reset = 1'b1;
    tick(3);
    chk("release_hold", bus.dout, 64'h0);

    // Sequential stepping with an idle (undriven) immediate.
    bus.imm = 'x;
    for (int k = 1; k <= 3; k++) begin
      pulse();
      chk("seq_step", bus.dout, 64'(4 * k));
      tick(4);
      chk("seq_hold", bus.dout, 64'(4 * k));
    end

    // Move to 0x40, then assert reset mid-cycle with the enable high.
    bus.soma_imm = 1'b1;
    bus.imm      = 64'h34;
    pulse();
    chk("pc_0x40", bus.dout, 64'h40);
    bus.atualiza_pc = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("async_reset", bus.dout, RV);
    tick(3);
    chk("reset_wins", bus.dout, RV);
    bus.atualiza_pc = 1'b0;
    reset = 1'b1;
    tick(3);
    chk("post_reset_hold", bus.dout, 64'h0);

    // Forward and backward branches.
    bus.imm = 64'h100;
    pulse();
    chk("pc_0x100", bus.dout, 64'h100);
    bus.imm = 64'h20;
    #1;
    chk("fwd_next", bus.next_pc, 64'h120);
    chk("fwd_plus4", bus.pc_plus4, 64'h104);
    pulse();
    chk("fwd_dout", bus.dout, 64'h120);
    chk("fwd_plus4_after", bus.pc_plus4, 64'h124);
    bus.imm = 64'hFFFF_FFFF_FFFF_FFF8;
    #1;
    chk("bwd_next", bus.next_pc, 64'h118);
    pulse();
    chk("bwd_dout", bus.dout, 64'h118);

    // Misaligned target still loads.
    bus.imm = 64'hFFFF_FFFF_FFFF_FFE8;
    pulse();
    chk("back_0x100", bus.dout, 64'h100);
    bus.imm = 64'h2;
    #1;
    chk("mis_next", bus.next_pc, 64'h102);
    chk("mis_flag", {63'd0, bus.misaligned}, 64'd1);
    pulse();
    chk("mis_dout", bus.dout, 64'h102);

    // Wrap-around at the top of the address space.
    bus.imm = 64'hFFFF_FFFF_FFFF_FEFA;
    pulse();
    chk("top_dout", bus.dout, 64'hFFFF_FFFF_FFFF_FFFC);
    bus.soma_imm = 1'b0;
    bus.imm      = 'x;
    #1;
    chk("wrap_next", bus.next_pc, 64'h0);
    chk("wrap_plus4", bus.pc_plus4, 64'h0);
    pulse();
    chk("wrap_dout", bus.dout, 64'h0);

    // Enable low: PC frozen across 10 edges.
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("en_low_hold", bus.dout, 64'h0);
    end

    // Enable held high for 3 edges advances 3 times.
    bus.atualiza_pc = 1'b1;
    tick(3);
    bus.atualiza_pc = 1'b0;
    chk("multi_advance", bus.dout, 64'hC);

    // Only the immediate present at the enabled edge is captured.
    bus.soma_imm = 1'b1;
    bus.imm      = 64'h10;
    #3 bus.imm   = 64'h20;
    bus.atualiza_pc = 1'b1;
    @(posedge clk);
    #1 bus.atualiza_pc = 1'b0;
    chk("late_imm", bus.dout, 64'h2C);

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- 64-bit program-counter block for the multi-cycle RISC-V datapath: a PC register plus the dedicated PC adder ("next-PC ALU").
- The control unit pulses an update enable once per instruction, in the fetch state.
- The adder selects sequential (PC+4) or PC-relative (PC+imm) next address.
- Outputs feed instruction memory addressing and the link-address path.

Parameters:
- XLEN, 64, datapath width of PC, immediate and adder.
- RESET_VECTOR, 64'h0, PC value loaded on reset.
- INSTR_BYTES, 4, sequential increment in bytes.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- atualiza_pc  input  1  update enable; PC loads next_pc on the rising clk edge when 1.
- soma_imm  input  1  next-PC select: 1 = PC+imm, 0 = PC+INSTR_BYTES.
- imm  input  XLEN  sign-extended byte offset from the immediate generator; two's complement.
- dout  output  XLEN  current PC (register output).
- next_pc  output  XLEN  combinational next-PC (adder result).
- pc_plus4  output  XLEN  combinational dout+INSTR_BYTES, always available for link writes.
- misaligned  output  1  combinational: next_pc[1:0] != 2'b00.

Behaviour:
- Reset: reset=0 forces dout=RESET_VECTOR immediately, without waiting for a clock edge, and holds it while low. Combinational outputs follow from that value.
- Reset values with RESET_VECTOR=0 and soma_imm=0: dout=0, next_pc=4, pc_plus4=4, misaligned=0.
- Reset release: PC holds RESET_VECTOR until the first rising edge with atualiza_pc=1.
- Update: on rising clk, if reset=1 and atualiza_pc=1, dout <= next_pc. If atualiza_pc=0, dout holds. Latency is one edge: the new PC is visible on dout after that edge.
- Adder: next_pc = soma_imm ? dout + imm : dout + INSTR_BYTES.
- Arithmetic is modulo 2^XLEN. No overflow detection; wrap-around is silent, e.g. 64'hFFFF_FFFF_FFFF_FFFC+4 = 0.
- Negative imm (backward branch) is plain two's-complement addition. The block does no shifting of imm; the immediate generator supplies byte offsets.
- pc_plus4 is independent of soma_imm.
- misaligned is informational only. The PC still loads a misaligned next_pc; trap handling belongs to the control unit.
- atualiza_pc is a synchronous enable. It is never used as a clock.
- The control unit asserts atualiza_pc in exactly one cycle per instruction: the fetch state of init→fetch→decode→ex→wb→fetch. The block does not enforce this.
- Holding atualiza_pc high for N cycles advances the PC N times.
- Simultaneous reset low and atualiza_pc high: reset wins.
- Reset asserted mid-operation aborts any pending update.
- imm or soma_imm changing between edges affects next_pc only combinationally. Only the value present at the enabled edge is captured.
- No X propagation from an idle imm when soma_imm=0: the bench drives imm=X and checks next_pc is still defined.

Decomposition:
- Shared package riscv_pkg: XLEN, INSTR_BYTES, RESET_VECTOR default.
- Also in riscv_pkg: the control-unit state encoding (init=0, fetch=1, decode=2, ex=3, wb=4) and the add/sub selector constants (nao=0, soma=1, subtrai=2) used by the surrounding control.
- One sub-module: pc_adder, a purely combinational unit holding the adder, the soma_imm mux, pc_plus4 and misaligned.
- pc_unit instantiates pc_adder and contains the register.

Test Plan:
- Reset: assert reset=0 asynchronously mid-cycle with PC=0x40 → dout=0 before the next clk edge; after release, dout stays 0 until atualiza_pc=1.
- Sequential: atualiza_pc pulsed for one cycle every 5 cycles, soma_imm=0, from 0 → dout 4, 8, 12 after each pulse; unchanged in the other cycles.
- Branch forward/backward: PC=0x100, soma_imm=1, imm=0x20 → 0x120. Then imm=-8 (64'hFFFF_FFFF_FFFF_FFF8) → 0x118. pc_plus4 is 0x104, then 0x124, regardless of soma_imm.
- Wrap-around: PC=64'hFFFF_FFFF_FFFF_FFFC, soma_imm=0, update → dout=0.
- Enable/priority: atualiza_pc=0 for 10 edges → dout constant. atualiza_pc=1 with reset=0 → dout=RESET_VECTOR.
- Misaligned: PC=0x100, soma_imm=1, imm=2 → next_pc=0x102, misaligned=1; after update dout=0x102.
